mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS
//  pipeline, generalised in datapath width and multiply latency. Sits beside
//  the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU from EX and raises busy_o,
//  which the hazard logic uses to stall. Holds the architectural HI/LO registers
//  for MFHI/MFLO and MTHI/MTLO.
// PARAMETERS
//  DATA_W      32  operand, HI and LO width (even, >=8)
//  MUL_CYCLES  4   cycles from start to result for multiplies (>=1)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous reset, active-high
//  start_i   in   1       launch op; sampled only in IDLE
//  op_i      in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a_i       in   DATA_W  rs operand (multiplicand/dividend)
//  b_i       in   DATA_W  rt operand (multiplier/divisor)
//  flush_i   in   1       abort in-flight op (pipeline flush)
//  hi_we_i   in   1       MTHI write strobe
//  lo_we_i   in   1       MTLO write strobe
//  wdata_i   in   DATA_W  MTHI/MTLO data
//  busy_o    out  1       op in flight (state != IDLE)
//  done_o    out  1       1-cycle pulse; HI/LO show the new result this cycle
//  div0_o    out  1       1-cycle pulse with done_o when divisor was 0
//  hi_o      out  DATA_W  HI register
//  lo_o      out  DATA_W  LO register
// BEHAVIOUR
//  Reset (async, any time, including mid-op): state=IDLE, hi_o=lo_o=0, and
//   busy_o=done_o=div0_o=0. Any op in flight is lost.
//  States: IDLE, MUL, DIV, FIX.
//  - IDLE: if start_i and !flush_i, capture a_i, b_i and op_i. Go to MUL (op[1]=0)
//    or DIV (op[1]=1). Otherwise stay in IDLE.
//  - MUL: count MUL_CYCLES edges from the start edge. On the last edge, write
//    {HI,LO} = full 2*DATA_W product (signed for MULT, unsigned for MULTU) and go
//    to IDLE. done_o is high in the following cycle.
//  - DIV: on entry, take operand magnitudes for DIV, raw values for DIVU. Run
//    DATA_W radix-2 restoring iterations, one per cycle, then go to FIX.
//  - FIX: apply signs (DIV only). Quotient is negative iff the operand signs
//    differ. Remainder takes the dividend's sign. Write LO=quotient, HI=remainder,
//    pulse done_o and go to IDLE.
//    Start to done_o = DATA_W+2 cycles.
//  - All arithmetic is truncated to DATA_W bits. DIV of most-negative by -1
//    gives LO=most-negative and HI=0, with no trap.
//  - Divisor 0 (either divide): normal latency. Results are LO=all ones and
//    HI=dividend (raw a_i). div0_o pulses with done_o.
//  - busy_o is high from the cycle after an accepted start until the cycle
//    done_o is high. done_o and busy_o are never both 1.
//  - start_i while busy_o=1 is ignored; no queueing.
//  - flush_i while busy_o=1: state goes to IDLE on the next edge. HI/LO are
//    unchanged and there is no done_o. flush_i in IDLE blocks a same-cycle start.
//  - MTHI/MTLO: on a clock edge with hi_we_i/lo_we_i set, write wdata_i
//    (1-cycle latency). Allowed in any state. If the write lands on the same
//    edge as a result commit, the result commit wins. A later commit overwrites
//    the written value.
//  - hi_o and lo_o are driven directly from registers; there is no
//    combinational path from the inputs.
// TESTING
//  1. MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. done_o is
//     high exactly 4 cycles after start; busy_o is high for cycles 1..3.
//  2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//     MULT of the same operands -> HI=0, LO=1.
//  3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, with done_o at cycle 34.
//     DIVU 7/2 -> LO=3, HI=1.
//  4. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//     DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, with div0_o=1 in the same cycle as done_o.
//  5. Preload HI=0xAA. Start DIV, assert flush_i at cycle 10 and start_i at
//     cycle 5 -> busy_o=0 at cycle 11. No done_o, HI stays 0xAA, and the
//     cycle-5 start is ignored.
//  6. Assert rst mid-MULT (cycle 2) -> hi_o, lo_o and busy_o are 0 immediately.
//     A new MULT after reset completes normally.
//     Also: lo_we_i on the commit edge -> LO holds the product.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - MIPS multiply/divide unit with architectural HI/LO registers
// Multiplies commit after MUL_CYCLES edges; divides use a restoring loop plus a sign-fix cycle.
module mips_muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              div0_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_MAX = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d, div0_q, div0_d;

  logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, prod;
  logic [DATA_W-1:0]   mul_a, mul_b, a_mag, b_mag, q_res, r_res;
  logic                mul_sgn, in_sgn;
  logic [DATA_W:0]     rem_sh, rem_sub;

  assign in_sgn = ~op_i[0];
  assign a_mag  = (in_sgn && a_i[DATA_W-1]) ? -a_i : a_i;
  assign b_mag  = (in_sgn && b_i[DATA_W-1]) ? -b_i : b_i;

  // A single-cycle multiply commits straight from the input operands.
  assign mul_a     = (state_q == S_IDLE) ? a_i : a_q;
  assign mul_b     = (state_q == S_IDLE) ? b_i : b_q;
  assign mul_sgn   = (state_q == S_IDLE) ? in_sgn : sgn_q;
  assign mul_a_ext = {{DATA_W{mul_sgn & mul_a[DATA_W-1]}}, mul_a};
  assign mul_b_ext = {{DATA_W{mul_sgn & mul_b[DATA_W-1]}}, mul_b};
  assign prod      = mul_a_ext * mul_b_ext;

  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign q_res   = qneg_q ? -quo_q : quo_q;
  assign r_res   = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_we_i ? wdata_i : hi_q;
    lo_d    = lo_we_i ? wdata_i : lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          a_d   = a_i;
          b_d   = b_i;
          sgn_d = in_sgn;
          if (op_i[1]) begin
            state_d = S_DIV;
            cnt_d   = DIV_LAST;
            dvs_d   = b_mag;
            quo_d   = a_mag;
            rem_d   = '0;
            qneg_d  = in_sgn & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
            rneg_d  = in_sgn & a_i[DATA_W-1];
          end else if (MUL_CYCLES == 1) begin
            {hi_d, lo_d} = prod;
            done_d       = 1'b1;
          end else begin
            state_d = S_MUL;
            cnt_d   = MUL_LAST;
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (!rem_sub[DATA_W]) begin
            rem_d = rem_sub[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          if (b_q == '0) begin
            lo_d   = '1;
            hi_d   = a_q;
            div0_d = 1'b1;
          end else begin
            lo_d = q_res;
            hi_d = r_res;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign div0_o = div0_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - directed and random checks of mips_muldiv_unit against an arithmetic model
module tb_mips_muldiv_unit;

  localparam int W       = 32;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         flush_i = 1'b0;
  logic         hi_we_i = 1'b0;
  logic         lo_we_i = 1'b0;
  logic [W-1:0] wdata_i = '0;
  logic         busy_o, done_o, div0_o;
  logic [W-1:0] hi_o, lo_o;

  int compared   = 0;
  int mismatched = 0;

  mips_muldiv_unit #(.DATA_W(W), .MUL_CYCLES(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .div0_o(div0_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, sp;
    longint unsigned up;
    int ia, ib;
    dz = 1'b0;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        {hi, lo} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      default: begin
        if (b == 0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (op == 2'b11) begin
          lo = a / b; hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = a; hi = '0;
        end else begin
          ia = $signed(a); ib = $signed(b);
          lo = ia / ib; hi = ia % ib;
        end
      end
    endcase
  endfunction

  // Launches one op, follows it to done_o and checks latency, busy, results; lw_cyc injects MTLO.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lw_cyc);
    logic [W-1:0] eh, el;
    logic ez;
    int k;
    model(op, a, b, eh, el, ez);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    step();
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    k = 1;
    while (k <= 60 && !done_o) begin
      chk({tag, ".busy"}, 64'(busy_o), 64'd1);
      if (k == lw_cyc) begin
        lo_we_i = 1'b1; wdata_i = 32'h1234_5678;
      end
      step();
      lo_we_i = 1'b0;
      k++;
    end
    chk({tag, ".lat"}, 64'(k), 64'(op[1] ? DIV_LAT : MUL_LAT));
    chk({tag, ".busy_at_done"}, 64'(busy_o), 64'd0);
    chk({tag, ".hi"}, 64'(hi_o), 64'(eh));
    chk({tag, ".lo"}, 64'(lo_o), 64'(el));
    chk({tag, ".div0"}, 64'(div0_o), 64'(ez));
    step();
    chk({tag, ".done_pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         seen;

    #1;
    chk("async_rst.hi", 64'(hi_o), 64'd0);
    step(); step();
    rst = 1'b0;
    chk("rst.hi", 64'(hi_o), 64'd0);
    chk("rst.lo", 64'(lo_o), 64'd0);
    chk("rst.busy", 64'(busy_o), 64'd0);
    chk("rst.done", 64'(done_o), 64'd0);
    chk("rst.div0", 64'(div0_o), 64'd0);

    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, -1);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("mult_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2, -1);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("divu_5_0", 2'b11, 32'd5, 32'd0, -1);
    run_op("div_m9_0", 2'b10, 32'hFFFF_FFF7, 32'd0, -1);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, -1);

    // Flush mid-divide: preloaded HI survives, no done, ignored in-flight start.
    hi_we_i = 1'b1; wdata_i = 32'hAA;
    step();
    hi_we_i = 1'b0;
    chk("mthi.hi", 64'(hi_o), 64'hAA);
    op_i = 2'b10; a_i = 32'd100; b_i = 32'd3; start_i = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      start_i = (c == 5);
      op_i    = 2'b00;
      flush_i = (c == 10);
      seen    = seen | done_o;
    end
    step();
    flush_i = 1'b0;
    chk("flush.busy", 64'(busy_o), 64'd0);
    for (int c = 0; c < 40; c++) begin
      seen = seen | done_o | busy_o;
      step();
    end
    chk("flush.no_done", 64'(seen), 64'd0);
    chk("flush.hi", 64'(hi_o), 64'hAA);

    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01;
    step();
    start_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush_blocks.busy", 64'(busy_o), 64'd0);
    step();
    chk("idle_flush_blocks.done", 64'(done_o), 64'd0);

    // Async reset in the middle of a multiply.
    lo_we_i = 1'b1; wdata_i = 32'h55;
    step();
    lo_we_i = 1'b0;
    op_i = 2'b00; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    step(); start_i = 1'b0;
    step();
    chk("pre_rst.busy", 64'(busy_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.hi", 64'(hi_o), 64'd0);
    chk("mid_rst.lo", 64'(lo_o), 64'd0);
    chk("mid_rst.busy", 64'(busy_o), 64'd0);
    step();
    rst = 1'b0;
    run_op("mult_after_rst", 2'b00, 32'd12345, 32'hFFFF_FF00, -1);
    run_op("mtlo_on_commit", 2'b01, 32'hDEAD_BEEF, 32'd3, MUL_LAT - 1);
    run_op("mtlo_before_commit", 2'b00, 32'd77, 32'd11, 1);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), rop, ra, rb, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
